// File: rtl/rs_station_pkg.sv
// Shared widths, instruction ids and entry payload types for the reservation station.
package rs_station_pkg;

    localparam int unsigned RSSize       = 16;
    localparam int unsigned RSIdxWidth   = 4;
    localparam int unsigned InstrIdWidth = 6;
    localparam int unsigned ImmWidth     = 32;
    localparam int unsigned WordWidth    = 32;
    localparam int unsigned AddrWidth    = 32;
    localparam int unsigned ROBIdxWidth  = 4;

    localparam logic [InstrIdWidth-1:0] InstrAdd  = InstrIdWidth'(1);
    localparam logic [InstrIdWidth-1:0] InstrAddi = InstrIdWidth'(2);
    localparam logic [InstrIdWidth-1:0] InstrBeq  = InstrIdWidth'(3);
    localparam logic [InstrIdWidth-1:0] InstrJal  = InstrIdWidth'(4);

    typedef struct packed {
        logic [WordWidth-1:0]   val;
        logic [ROBIdxWidth-1:0] tag;
        logic                   pend;
    } operand_t;

    typedef struct packed {
        logic                    busy;
        logic [InstrIdWidth-1:0] instr_id;
        logic [ImmWidth-1:0]     imm;
        logic [AddrWidth-1:0]    pc;
        logic [ROBIdxWidth-1:0]  dest;
        operand_t                j;
        operand_t                k;
    } rs_entry_t;

    // Capture a pending operand from the result buses; EX has priority over LSB.
    function automatic operand_t wakeup(
        input operand_t               op,
        input logic                   ex_en,
        input logic [ROBIdxWidth-1:0] ex_tag,
        input logic [WordWidth-1:0]   ex_res,
        input logic                   lsb_en,
        input logic [ROBIdxWidth-1:0] lsb_tag,
        input logic [WordWidth-1:0]   lsb_res
    );
        operand_t r;
        r = op;
        if (op.pend) begin
            if (ex_en && ex_tag == op.tag) begin
                r.val  = ex_res;
                r.pend = 1'b0;
            end else if (lsb_en && lsb_tag == op.tag) begin
                r.val  = lsb_res;
                r.pend = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/rs_station_prio_enc.sv
// Lowest-index priority encoder: returns the index of the first set request bit.
module rs_prio_enc #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned IDX_W = 4
) (
    input  logic [WIDTH-1:0] req,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            if (req[i] && !found) begin
                idx   = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_station.sv
// Reservation station: buffers dispatched ALU/branch ops, snoops EX/LSB results, issues one ready op per cycle.
// Optional RS_PERF_CNT_EN adds issue and full-cycle performance counters.
module rs_station
    import rs_station_pkg::*;
#(
    parameter int unsigned RS_SIZE  = RSSize,
    parameter int unsigned RS_IDX_W = RSIdxWidth
) (
    input  logic                    clk_in,
    input  logic                    rst_in,
    input  logic                    rdy_in,
    input  logic                    rollback_in,
    input  logic                    dispatch_en_in,
    input  logic [InstrIdWidth-1:0] instr_id_in,
    input  logic [ImmWidth-1:0]     imm_in,
    input  logic [AddrWidth-1:0]    pc_in,
    input  logic [ROBIdxWidth-1:0]  rob_pos_in,
    input  logic [WordWidth-1:0]    vj_in,
    input  logic [WordWidth-1:0]    vk_in,
    input  logic [ROBIdxWidth-1:0]  qj_in,
    input  logic [ROBIdxWidth-1:0]  qk_in,
    input  logic                    qj_valid_in,
    input  logic                    qk_valid_in,
    output logic                    full_out,
    input  logic                    ex_en_in,
    input  logic [WordWidth-1:0]    ex_res_in,
    input  logic [ROBIdxWidth-1:0]  ex_rob_pos_in,
    input  logic                    lsb_en_in,
    input  logic [WordWidth-1:0]    lsb_res_in,
    input  logic [ROBIdxWidth-1:0]  lsb_rob_pos_in,
`ifdef RS_PERF_CNT_EN
    output logic [31:0]             perf_issue_cnt_out,
    output logic [31:0]             perf_full_cnt_out,
`endif
    output logic                    rs_to_ex_en_out,
    output logic [InstrIdWidth-1:0] instr_id_out,
    output logic [ImmWidth-1:0]     imm_out,
    output logic [WordWidth-1:0]    rs1_out,
    output logic [WordWidth-1:0]    rs2_out,
    output logic [AddrWidth-1:0]    pc_out,
    output logic [ROBIdxWidth-1:0]  rob_pos_out
);

    rs_entry_t ent_q   [RS_SIZE];
    rs_entry_t ent_nxt [RS_SIZE];

    logic [RS_SIZE-1:0]      busy_vec;
    logic [RS_SIZE-1:0]      ready_vec;
    logic [RS_IDX_W-1:0]     free_idx;
    logic [RS_IDX_W-1:0]     ready_idx;
    logic                    free_found;
    logic                    ready_found;

    logic                    en_nxt;
    logic [InstrIdWidth-1:0] instr_id_nxt;
    logic [ImmWidth-1:0]     imm_nxt;
    logic [WordWidth-1:0]    rs1_nxt;
    logic [WordWidth-1:0]    rs2_nxt;
    logic [AddrWidth-1:0]    pc_nxt;
    logic [ROBIdxWidth-1:0]  rob_pos_nxt;

    rs_entry_t               disp_ent;

    always_comb begin
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            busy_vec[i]  = ent_q[i].busy;
            ready_vec[i] = ent_q[i].busy && !ent_q[i].j.pend && !ent_q[i].k.pend;
        end
    end

    assign full_out = &busy_vec;

    rs_prio_enc #(.WIDTH(RS_SIZE), .IDX_W(RS_IDX_W)) u_free_enc (
        .req   (~busy_vec),
        .idx   (free_idx),
        .found (free_found)
    );

    rs_prio_enc #(.WIDTH(RS_SIZE), .IDX_W(RS_IDX_W)) u_ready_enc (
        .req   (ready_vec),
        .idx   (ready_idx),
        .found (ready_found)
    );

    // Incoming entry with operands already woken by same-cycle broadcasts.
    always_comb begin
        disp_ent          = '0;
        disp_ent.busy     = 1'b1;
        disp_ent.instr_id = instr_id_in;
        disp_ent.imm      = imm_in;
        disp_ent.pc       = pc_in;
        disp_ent.dest     = rob_pos_in;
        disp_ent.j        = wakeup('{val: vj_in, tag: qj_in, pend: qj_valid_in},
                                   ex_en_in, ex_rob_pos_in, ex_res_in,
                                   lsb_en_in, lsb_rob_pos_in, lsb_res_in);
        disp_ent.k        = wakeup('{val: vk_in, tag: qk_in, pend: qk_valid_in},
                                   ex_en_in, ex_rob_pos_in, ex_res_in,
                                   lsb_en_in, lsb_rob_pos_in, lsb_res_in);
    end

    always_comb begin
        ent_nxt      = ent_q;
        en_nxt       = 1'b0;
        instr_id_nxt = instr_id_out;
        imm_nxt      = imm_out;
        rs1_nxt      = rs1_out;
        rs2_nxt      = rs2_out;
        pc_nxt       = pc_out;
        rob_pos_nxt  = rob_pos_out;
        if (rollback_in) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                ent_nxt[i].busy = 1'b0;
            end
            instr_id_nxt = '0;
            imm_nxt      = '0;
            rs1_nxt      = '0;
            rs2_nxt      = '0;
            pc_nxt       = '0;
            rob_pos_nxt  = '0;
        end else begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                if (ent_q[i].busy) begin
                    ent_nxt[i].j = wakeup(ent_q[i].j, ex_en_in, ex_rob_pos_in, ex_res_in,
                                          lsb_en_in, lsb_rob_pos_in, lsb_res_in);
                    ent_nxt[i].k = wakeup(ent_q[i].k, ex_en_in, ex_rob_pos_in, ex_res_in,
                                          lsb_en_in, lsb_rob_pos_in, lsb_res_in);
                end
            end
            if (ready_found) begin
                en_nxt                 = 1'b1;
                instr_id_nxt           = ent_q[ready_idx].instr_id;
                imm_nxt                = ent_q[ready_idx].imm;
                rs1_nxt                = ent_q[ready_idx].j.val;
                rs2_nxt                = ent_q[ready_idx].k.val;
                pc_nxt                 = ent_q[ready_idx].pc;
                rob_pos_nxt            = ent_q[ready_idx].dest;
                ent_nxt[ready_idx].busy = 1'b0;
            end
            // Free slot is never the issuing slot, so both updates can coexist.
            if (dispatch_en_in && free_found) begin
                ent_nxt[free_idx] = disp_ent;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < int'(RS_SIZE); i++) begin
                ent_q[i] <= '0;
            end
            rs_to_ex_en_out <= 1'b0;
            instr_id_out    <= '0;
            imm_out         <= '0;
            rs1_out         <= '0;
            rs2_out         <= '0;
            pc_out          <= '0;
            rob_pos_out     <= '0;
        end else if (rdy_in) begin
            ent_q           <= ent_nxt;
            rs_to_ex_en_out <= en_nxt;
            instr_id_out    <= instr_id_nxt;
            imm_out         <= imm_nxt;
            rs1_out         <= rs1_nxt;
            rs2_out         <= rs2_nxt;
            pc_out          <= pc_nxt;
            rob_pos_out     <= rob_pos_nxt;
        end else begin
            rs_to_ex_en_out <= 1'b0;
        end
    end

`ifdef RS_PERF_CNT_EN
    // Counters survive rollback; only reset clears them.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            perf_issue_cnt_out <= '0;
            perf_full_cnt_out  <= '0;
        end else begin
            if (rdy_in && !rollback_in && ready_found) begin
                perf_issue_cnt_out <= perf_issue_cnt_out + 32'd1;
            end
            if (rdy_in && full_out) begin
                perf_full_cnt_out <= perf_full_cnt_out + 32'd1;
            end
        end
    end
`endif

    no_dispatch_when_full: assert property (@(posedge clk_in) disable iff (rst_in)
        !(rdy_in && !rollback_in && dispatch_en_in && full_out));

endmodule

// File: tb/tb_rs_station.sv
// Self-checking bench for rs_station: vector table, directed corner sequences and randomized model comparison.
module tb_rs_station;
    import rs_station_pkg::*;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic                    rdy = 1'b1;
    logic                    rollback = 1'b0;
    logic                    disp = 1'b0;
    logic [InstrIdWidth-1:0] instr_id = '0;
    logic [ImmWidth-1:0]     imm = '0;
    logic [AddrWidth-1:0]    pc = '0;
    logic [ROBIdxWidth-1:0]  rob = '0;
    logic [WordWidth-1:0]    vj = '0, vk = '0;
    logic [ROBIdxWidth-1:0]  qj = '0, qk = '0;
    logic                    qjv = 1'b0, qkv = 1'b0;
    logic                    ex_en = 1'b0, lsb_en = 1'b0;
    logic [WordWidth-1:0]    ex_res = '0, lsb_res = '0;
    logic [ROBIdxWidth-1:0]  ex_tag = '0, lsb_tag = '0;

    logic                    full, en;
    logic [InstrIdWidth-1:0] id_o;
    logic [ImmWidth-1:0]     imm_o;
    logic [WordWidth-1:0]    rs1_o, rs2_o;
    logic [AddrWidth-1:0]    pc_o;
    logic [ROBIdxWidth-1:0]  rob_o;

    int checks = 0;
    int failures = 0;

    rs_station dut (
        .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .rollback_in(rollback),
        .dispatch_en_in(disp), .instr_id_in(instr_id), .imm_in(imm), .pc_in(pc),
        .rob_pos_in(rob), .vj_in(vj), .vk_in(vk), .qj_in(qj), .qk_in(qk),
        .qj_valid_in(qjv), .qk_valid_in(qkv), .full_out(full),
        .ex_en_in(ex_en), .ex_res_in(ex_res), .ex_rob_pos_in(ex_tag),
        .lsb_en_in(lsb_en), .lsb_res_in(lsb_res), .lsb_rob_pos_in(lsb_tag),
        .rs_to_ex_en_out(en), .instr_id_out(id_o), .imm_out(imm_o),
        .rs1_out(rs1_o), .rs2_out(rs2_o), .pc_out(pc_o), .rob_pos_out(rob_o)
    );

    always #5 clk = ~clk;

    // Behavioural reference: a bag of slots described directly by the dispatch/snoop/issue rules.
    bit        m_busy [16];
    bit        m_pj [16], m_pk [16];
    bit [31:0] m_vj [16], m_vk [16], m_imm [16], m_pc [16];
    bit [5:0]  m_id [16];
    bit [3:0]  m_qj [16], m_qk [16], m_dest [16];
    bit        o_en;
    bit [31:0] o_imm, o_rs1, o_rs2, o_pc;
    bit [5:0]  o_id;
    bit [3:0]  o_rob;

    function automatic bit model_full();
        int n = 0;
        foreach (m_busy[i]) n += int'(m_busy[i]);
        return n == 16;
    endfunction

    task automatic model_step();
        int sel = -1;
        int fr = -1;
        if (rst) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            {o_en, o_id, o_imm, o_rs1, o_rs2, o_pc, o_rob} = '0;
        end else if (!rdy) begin
            o_en = 0;
        end else if (rollback) begin
            foreach (m_busy[i]) m_busy[i] = 0;
            {o_en, o_id, o_imm, o_rs1, o_rs2, o_pc, o_rob} = '0;
        end else begin
            for (int i = 15; i >= 0; i--) begin
                if (m_busy[i] && !m_pj[i] && !m_pk[i]) sel = i;
                if (!m_busy[i]) fr = i;
            end
            for (int i = 0; i < 16; i++) begin
                if (!m_busy[i]) continue;
                if (m_pj[i] && ex_en && ex_tag == m_qj[i]) begin m_vj[i] = ex_res; m_pj[i] = 0; end
                else if (m_pj[i] && lsb_en && lsb_tag == m_qj[i]) begin m_vj[i] = lsb_res; m_pj[i] = 0; end
                if (m_pk[i] && ex_en && ex_tag == m_qk[i]) begin m_vk[i] = ex_res; m_pk[i] = 0; end
                else if (m_pk[i] && lsb_en && lsb_tag == m_qk[i]) begin m_vk[i] = lsb_res; m_pk[i] = 0; end
            end
            o_en = (sel >= 0);
            if (sel >= 0) begin
                o_id = m_id[sel]; o_imm = m_imm[sel]; o_rs1 = m_vj[sel];
                o_rs2 = m_vk[sel]; o_pc = m_pc[sel]; o_rob = m_dest[sel];
                m_busy[sel] = 0;
            end
            if (disp && fr >= 0) begin
                m_busy[fr] = 1; m_id[fr] = instr_id; m_imm[fr] = imm; m_pc[fr] = pc;
                m_dest[fr] = rob; m_qj[fr] = qj; m_qk[fr] = qk;
                m_vj[fr] = vj; m_pj[fr] = qjv;
                m_vk[fr] = vk; m_pk[fr] = qkv;
                if (qjv && ex_en && ex_tag == qj) begin m_vj[fr] = ex_res; m_pj[fr] = 0; end
                else if (qjv && lsb_en && lsb_tag == qj) begin m_vj[fr] = lsb_res; m_pj[fr] = 0; end
                if (qkv && ex_en && ex_tag == qk) begin m_vk[fr] = ex_res; m_pk[fr] = 0; end
                else if (qkv && lsb_en && lsb_tag == qk) begin m_vk[fr] = lsb_res; m_pk[fr] = 0; end
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: update model with pre-edge inputs, then compare DUT against it after the edge.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        chk("model_full", 64'(full), 64'(model_full()));
        chk("model_en", 64'(en), 64'(o_en));
        chk("model_rs1", 64'(rs1_o), 64'(o_rs1));
        chk("model_rs2", 64'(rs2_o), 64'(o_rs2));
        chk("model_imm", 64'(imm_o), 64'(o_imm));
        chk("model_pc", 64'(pc_o), 64'(o_pc));
        chk("model_id", 64'(id_o), 64'(o_id));
        chk("model_rob", 64'(rob_o), 64'(o_rob));
    endtask

    task automatic clear_in();
        rst = 0; rdy = 1; rollback = 0; disp = 0; ex_en = 0; lsb_en = 0;
        qjv = 0; qkv = 0;
    endtask

    task automatic do_reset();
        clear_in();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic set_disp(input logic [5:0] id_v, input logic [31:0] imm_v, input logic [3:0] rob_v,
                            input logic [31:0] vj_v, input logic qjv_v, input logic [3:0] qj_v,
                            input logic [31:0] vk_v, input logic qkv_v, input logic [3:0] qk_v);
        disp = 1; instr_id = id_v; imm = imm_v; rob = rob_v; pc = 32'h1000 + 32'(rob_v) * 4;
        vj = vj_v; qjv = qjv_v; qj = qj_v; vk = vk_v; qkv = qkv_v; qk = qk_v;
    endtask

    typedef struct {
        logic [5:0]  id;
        logic [31:0] imm_v;
        logic [31:0] vj_v, vk_v;
        logic [3:0]  qj_v, qk_v;
        logic        qjv_v, qkv_v;
        logic        ex_en_v;
        logic [3:0]  ex_tag_v;
        logic [31:0] ex_res_v;
        logic        lsb_en_v;
        logic [3:0]  lsb_tag_v;
        logic [31:0] lsb_res_v;
        logic        exp_en;
        logic [31:0] exp_rs1, exp_rs2;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{InstrAddi, 32'd3, 32'd5, 32'd0, 4'd0, 4'd0, 1'b0, 1'b0,
                    1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b1, 32'd5, 32'd0};
        vecs[1] = '{InstrAdd, 32'd0, 32'h11, 32'h99, 4'd0, 4'd4, 1'b0, 1'b1,
                    1'b0, 4'd0, 32'd0, 1'b1, 4'd4, 32'hAB, 1'b1, 32'h11, 32'hAB};
        vecs[2] = '{InstrAdd, 32'd0, 32'h1, 32'h2, 4'd6, 4'd0, 1'b1, 1'b0,
                    1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 32'd0};
        vecs[3] = '{InstrBeq, 32'h8, 32'h1, 32'h2, 4'd2, 4'd5, 1'b1, 1'b1,
                    1'b1, 4'd2, 32'h20, 1'b1, 4'd5, 32'h50, 1'b1, 32'h20, 32'h50};
        vecs[4] = '{InstrJal, 32'h40, 32'h44, 32'h0, 4'd3, 4'd0, 1'b0, 1'b0,
                    1'b1, 4'd3, 32'h77, 1'b0, 4'd0, 32'd0, 1'b1, 32'h44, 32'h0};
        vecs[5] = '{InstrAdd, 32'd0, 32'h1, 32'h2, 4'd0, 4'd9, 1'b0, 1'b1,
                    1'b1, 4'd8, 32'h88, 1'b1, 4'd7, 32'h66, 1'b0, 32'd0, 32'd0};

        do_reset();
        chk("reset_en", 64'(en), 64'd0);
        chk("reset_full", 64'(full), 64'd0);
        chk("reset_rob", 64'(rob_o), 64'd0);

        // Single-instruction vectors: dispatch one cycle, check issue on the following cycle.
        for (int v = 0; v < 6; v++) begin
            do_reset();
            set_disp(vecs[v].id, vecs[v].imm_v, 4'(v + 2), vecs[v].vj_v, vecs[v].qjv_v, vecs[v].qj_v,
                     vecs[v].vk_v, vecs[v].qkv_v, vecs[v].qk_v);
            ex_en = vecs[v].ex_en_v; ex_tag = vecs[v].ex_tag_v; ex_res = vecs[v].ex_res_v;
            lsb_en = vecs[v].lsb_en_v; lsb_tag = vecs[v].lsb_tag_v; lsb_res = vecs[v].lsb_res_v;
            tick();
            chk("vec_no_issue_at_dispatch", 64'(en), 64'd0);
            clear_in();
            tick();
            chk("vec_en", 64'(en), 64'(vecs[v].exp_en));
            if (vecs[v].exp_en) begin
                chk("vec_rs1", 64'(rs1_o), 64'(vecs[v].exp_rs1));
                chk("vec_rs2", 64'(rs2_o), 64'(vecs[v].exp_rs2));
                chk("vec_imm", 64'(imm_o), 64'(vecs[v].imm_v));
                chk("vec_rob", 64'(rob_o), 64'(v + 2));
                chk("vec_id", 64'(id_o), 64'(vecs[v].id));
            end
            tick();
            chk("vec_en_drop", 64'(en), 64'd0);
        end

        // Pending on tag 7, woken by EX three cycles later.
        do_reset();
        set_disp(InstrAdd, 32'd0, 4'd1, 32'd0, 1'b1, 4'd7, 32'd2, 1'b0, 4'd0);
        tick();
        clear_in();
        tick(); tick();
        chk("wake_wait", 64'(en), 64'd0);
        ex_en = 1; ex_tag = 4'd7; ex_res = 32'h10;
        tick();
        chk("wake_capture_edge", 64'(en), 64'd0);
        clear_in();
        tick();
        chk("wake_en", 64'(en), 64'd1);
        chk("wake_rs1", 64'(rs1_o), 64'h10);

        // Fill all 16 slots, free slot 0 and reuse it.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            set_disp(InstrAdd, 32'(i), 4'(i), 32'd0, 1'b1, 4'(i), 32'd0, 1'b0, 4'd0);
            tick();
        end
        clear_in();
        chk("fill_full", 64'(full), 64'd1);
        ex_en = 1; ex_tag = 4'd0; ex_res = 32'h1;
        tick();
        chk("fill_still_full", 64'(full), 64'd1);
        clear_in();
        tick();
        chk("fill_issue_en", 64'(en), 64'd1);
        chk("fill_issue_rob", 64'(rob_o), 64'd0);
        chk("fill_not_full", 64'(full), 64'd0);
        set_disp(InstrAddi, 32'h55, 4'd5, 32'd9, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        tick();
        chk("fill_refull", 64'(full), 64'd1);
        clear_in();
        tick();
        chk("fill_reuse_en", 64'(en), 64'd1);
        chk("fill_reuse_imm", 64'(imm_o), 64'h55);

        // Entries 3 and 9 wake together: lower index first.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            set_disp(InstrAdd, 32'd0, 4'(i), 32'd0, 1'b1, (i == 3 || i == 9) ? 4'd3 : 4'd12,
                     32'd0, 1'b0, 4'd0);
            tick();
        end
        clear_in();
        ex_en = 1; ex_tag = 4'd3; ex_res = 32'h33;
        tick();
        clear_in();
        tick();
        chk("prio_first", 64'(rob_o), 64'd3);
        chk("prio_first_en", 64'(en), 64'd1);
        tick();
        chk("prio_second", 64'(rob_o), 64'd9);
        chk("prio_second_rs1", 64'(rs1_o), 64'h33);
        tick();
        chk("prio_done", 64'(en), 64'd0);

        // Rollback beats a simultaneous dispatch.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            set_disp(InstrAdd, 32'd0, 4'(i), 32'd0, 1'b1, 4'd14, 32'd0, 1'b0, 4'd0);
            tick();
        end
        set_disp(InstrAddi, 32'd1, 4'd8, 32'd1, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        rollback = 1;
        tick();
        chk("rb_en", 64'(en), 64'd0);
        chk("rb_full", 64'(full), 64'd0);
        clear_in();
        tick();
        chk("rb_no_issue", 64'(en), 64'd0);
        chk("rb_rob_zero", 64'(rob_o), 64'd0);

        // rdy low freezes everything and silences issue.
        set_disp(InstrAddi, 32'd7, 4'd6, 32'hCAFE, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0);
        tick();
        clear_in();
        rdy = 0;
        tick(); tick();
        chk("stall_en", 64'(en), 64'd0);
        rdy = 1;
        tick();
        chk("stall_resume_en", 64'(en), 64'd1);
        chk("stall_resume_rs1", 64'(rs1_o), 64'hCAFE);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            clear_in();
            rdy = ($urandom_range(0, 9) != 0);
            rollback = ($urandom_range(0, 149) == 0);
            if (!model_full() && $urandom_range(0, 2) != 0)
                set_disp(6'($urandom_range(1, 4)), $urandom, 4'($urandom_range(0, 15)),
                         $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)),
                         $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)));
            ex_en = ($urandom_range(0, 1) != 0);
            ex_tag = 4'($urandom_range(0, 7));
            ex_res = $urandom;
            lsb_en = ($urandom_range(0, 2) == 0);
            lsb_tag = 4'($urandom_range(0, 7));
            if (ex_en && lsb_en && lsb_tag == ex_tag) lsb_tag = lsb_tag ^ 4'd1;
            lsb_res = $urandom;
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rs_station.md
Name: rs_station

Overview:
Reservation station: the issuing side of the RS→EX interface. It buffers decoded ALU/branch/jump instructions until their operands are ready, and snoops the EX and LSB result broadcasts to capture pending operands. Each cycle it issues at most one ready instruction to the combinational EX unit through registered outputs. It sits between the decoder/dispatch logic and EX.

Parameters:
RS_SIZE, 16, number of entries (power of two)
RS_IDX_W, 4, log2(RS_SIZE)

Ports:
clk_in  input  1  clock
rst_in  input  1  synchronous active-high reset
rdy_in  input  1  global ready; when low, all state holds and rs_to_ex_en_out is forced 0
rollback_in  input  1  misprediction flush
dispatch_en_in  input  1  new instruction valid
instr_id_in  input  InstrIdWidth  operation id
imm_in  input  ImmWidth  immediate
pc_in  input  AddrWidth  instruction pc
rob_pos_in  input  ROBIdxWidth  destination ROB slot
vj_in, vk_in  input  WordWidth  operand values
qj_in, qk_in  input  ROBIdxWidth  producer ROB tags
qj_valid_in, qk_valid_in  input  1  1 = operand pending on tag
full_out  output  1  no free entry
ex_en_in  input  1  EX result broadcast valid
ex_res_in  input  WordWidth  EX result
ex_rob_pos_in  input  ROBIdxWidth  EX result tag
lsb_en_in  input  1  LSB load result valid
lsb_res_in  input  WordWidth  load result
lsb_rob_pos_in  input  ROBIdxWidth  load tag
rs_to_ex_en_out  output  1  issue valid
instr_id_out  output  InstrIdWidth  issued op
imm_out  output  ImmWidth  issued imm
rs1_out, rs2_out  output  WordWidth  issued operand values
pc_out  output  AddrWidth  issued pc
rob_pos_out  output  ROBIdxWidth  issued ROB slot

Behaviour:
- Clock and reset: one clock, clk_in. Reset (rst_in) is synchronous and active-high. On reset or rollback_in at a rising edge: all busy bits cleared, every issue output 0, full_out 0. Rollback takes priority over dispatch, issue and snoop in the same cycle.
- Entry fields: busy, instr_id, imm, pc, dest, vj, qj, pj, vk, qk, pk. pj/pk = pending.
- full_out: combinational. It is 1 exactly when all RS_SIZE entries are busy, evaluated on registered state. A dispatch while full_out=1 is ignored (protocol violation; covered by an assertion).
- Dispatch: the entry is written into the lowest-index non-busy entry.
  - Operand j is pending only if qj_valid_in=1 and no broadcast that cycle matches qj_in. If ex_en_in and ex_rob_pos_in==qj_in, capture ex_res_in, pj=0. Otherwise, if lsb_en_in and the LSB tag matches, capture lsb_res_in. Operand k is handled the same way.
  - If both broadcasts match, EX wins. Both buses carrying the same tag is illegal.
- Snoop: every busy entry with pj=1 and qj equal to a valid broadcast tag captures that value and clears pj (same for k), at the edge of the broadcast cycle.
- Select: an entry is ready when busy & !pj & !pk on registered state. The lowest-index ready entry is issued.
  - At the edge, its fields load into the output registers, rs_to_ex_en_out=1 for exactly one cycle, and busy clears.
  - If no entry is ready, rs_to_ex_en_out=0. Other outputs hold their last values.
- Latency: dispatch with ready operands at edge N → rs_to_ex_en_out high during cycle N+1 (issued at edge N+1). A snooped wakeup at edge N → issue at edge N+1.
- Simultaneous dispatch and issue in one cycle is legal. A freed slot is reusable from the next cycle. A new entry never issues in its dispatch cycle.
- rdy_in=0: no state changes, inputs ignored, rs_to_ex_en_out=0.
- No state machine beyond per-entry busy/pending bits. Entry count is derived from the busy bits.

Optional Feature:
RS_PERF_CNT_EN:
- Defined: adds two 32-bit outputs. perf_issue_cnt_out increments per issue. perf_full_cnt_out increments per cycle with full_out=1 and rdy_in=1. Both are cleared by rst_in only (not by rollback) and wrap at 2^32.
- Undefined: the ports and counters do not exist.

Decomposition:
- config.vh gains the RS_SIZE/RS_IDX_W defaults (RSSize, RSIdxWidth). It already supplies InstrIdWidth, ImmWidth, WordWidth, AddrWidth, ROBIdxWidth and the instruction ids.
- One sub-module, rs_prio_enc: parameterised lowest-index priority encoder (RS_SIZE-bit vector → index + found flag). It is instantiated twice, for free-slot and ready-slot selection.

Test Plan:
- Reset, then dispatch ADDI (vj=5, imm=3, no pending, rob_pos=2) → next cycle rs_to_ex_en_out=1, rs1_out=5, imm_out=3, rob_pos_out=2; following cycle rs_to_ex_en_out=0.
- Dispatch ADD with qj=7 pending; three cycles later ex_en_in=1, tag=7, res=0x10 → issue one cycle after the broadcast with rs1_out=0x10.
- Dispatch with qk_in=4 while lsb_en_in=1, lsb_rob_pos_in=4, lsb_res_in=0xAB in the same cycle → captured at dispatch; issue next cycle with rs2_out=0xAB.
- Fill 16 pending entries → full_out=1. Broadcast the tag of entry 0 → entry 0 issues, full_out=0 the next cycle, and a new dispatch lands in slot 0.
- Entries 3 and 9 become ready in the same cycle → entry 3 issues first, entry 9 in the next cycle.
- Entries busy, then rollback_in=1 while dispatch_en_in=1 → all entries empty, no issue in the next cycle, full_out=0.
